adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares a single adder_64bit instance between NUM_REQ requesters, for example PC increment,
//  RSP +/-8 update and ALU add in the SEQ Execute stage.
//  Uses a round-robin grant, a valid/ready request per requester and one shared response channel
//  tagged with the requester index.
//  Operands and results are registered, so the combinational ripple adder never sits on a
//  requester-to-requester path.
// PARAMETERS
//  NUM_REQ  3   number of requesters (2..8)
//  ID_W     2   width of requester index; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   NUM_REQ     per-requester operand valid
//  req_a      in   NUM_REQ*64  operand A; requester i drives bits [64*i+63:64*i]
//  req_b      in   NUM_REQ*64  operand B, packed the same way as req_a
//  req_ready  out  NUM_REQ     one-hot accept; a request transfers when req_valid[i]&req_ready[i]
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer accepts result
//  rsp_sum    out  64          A+B modulo 2**64
//  rsp_carry  out  1           carry out of bit 63 (the adder's carry_overflow)
//  rsp_id     out  ID_W        index of the requester that owns the result
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0.
//  - Reset mid-operation: any in-flight transaction is dropped and no response is issued.
//    Reset overrides every other event in the same cycle.
//  - FSM states IDLE -> CALC -> RESP -> IDLE.
//  - IDLE, grant selection (combinational):
//    - Search starts at rr_ptr and wraps; winner w = first i with req_valid[i]=1.
//    - req_ready = one-hot(w), or 0 if no request is valid.
//    - req_ready is 0 in every state except IDLE.
//  - IDLE, on accept:
//    - op_a <= req_a[w]; op_b <= req_b[w]; id <= w.
//    - rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1.
//    - Go to CALC.
//  - CALC: rsp_sum <= op_a+op_b and rsp_carry <= carry, both from the internal adder;
//    rsp_id <= id; rsp_valid <= 1; go to RESP.
//  - RESP: rsp_valid=1; rsp_sum, rsp_carry and rsp_id are held stable until rsp_ready=1.
//    On rsp_valid&rsp_ready: rsp_valid <= 0, go to IDLE. rsp_sum, rsp_carry and rsp_id keep
//    their last values.
//  - Latency: accept in cycle t -> rsp_valid high in cycle t+2. Minimum interval between
//    accepts is 3 cycles (IDLE,CALC,RESP with rsp_ready already high).
//  - Requester obligations:
//    - A requester may lower req_valid at any cycle before it is accepted; this is not an error.
//    - Operands need only be valid in the accept cycle.
//    - Requests that are not granted are not captured.
//  - rr_ptr changes only on accept. Idle cycles and a stalled RESP do not move it.
//  - Simultaneous requests: exactly one is granted per accept. A requester that is continuously
//    valid is granted within NUM_REQ accepts (no starvation).
//  - Wrap-around: 64-bit overflow wraps silently; rsp_carry=1 reports it. No signed flags.
//  - rsp_ready while rsp_valid=0 is ignored.
// TESTING
//  1 Single request: req_valid=3'b010, a=5, b=7 -> req_ready=3'b010 at t; rsp_valid at t+2,
//    sum=12, carry=0, id=1.
//  2 Overflow: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, carry=1.
//    a=b=64'h8000_0000_0000_0000 -> sum=0, carry=1.
//  3 Round-robin: all three requesters held valid from reset with rsp_ready=1 -> grant order
//    0,1,2,0,1,2; accepts exactly 3 cycles apart.
//  4 Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> sum/carry/id stable, req_ready=0
//    throughout, rr_ptr unchanged; release rsp_ready -> IDLE the next cycle.
//  5 Reset mid-op: rst asserted in CALC -> next cycle rsp_valid=0, rr_ptr=0, IDLE; the dropped
//    request produces no response.
//  6 Withdraw: req_valid[2] asserted and then deasserted while in RESP -> never granted;
//    req_valid=3'b000 in IDLE -> req_ready=0, FSM remains IDLE.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 64-bit ripple adder between requesters.
// Operands and results are registered around the adder.
module adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        carry_in,
    output logic [63:0] sum,
    output logic        carry_overflow
);

    logic cy;

    always_comb begin
        sum = '0;
        cy  = carry_in;
        for (int i = 0; i < 64; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        carry_overflow = cy;
    end

endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*64-1:0]  req_a,
    input  logic [NUM_REQ*64-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [63:0]            rsp_sum,
    output logic                   rsp_carry,
    output logic [ID_W-1:0]        rsp_id
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_any;
    logic               accept;
    logic [63:0]        sel_a;
    logic [63:0]        sel_b;
    logic [63:0]        op_a;
    logic [63:0]        op_b;
    logic [ID_W-1:0]    op_id;
    logic [63:0]        add_sum;
    logic               add_carry;
    int                 idx;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any     = 1'b1;
                grant_id      = ID_W'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    // One-hot AND-OR operand select
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = sel_a | req_a[64*i +: 64];
                sel_b = sel_b | req_b[64*i +: 64];
            end
        end
    end

    assign accept    = (state == IDLE) && !rst && grant_any;
    assign req_ready = ((state == IDLE) && !rst) ? grant_oh : '0;

    adder_64bit u_adder (
        .a              (op_a),
        .b              (op_b),
        .carry_in       (1'b0),
        .sum            (add_sum),
        .carry_overflow (add_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= grant_id;
                if (grant_id == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_id + 1'b1;
                end
            end
            if (state == CALC) begin
                rsp_sum   <= add_sum;
                rsp_carry <= add_carry;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_adder_share_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*64-1:0] req_a;
    logic [N*64-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [63:0]    rsp_sum;
    logic           rsp_carry;
    logic [1:0]     rsp_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic int rr_pick(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Drives one request and returns what the DUT showed along the way.
    task automatic send(input int idx, input logic [63:0] a, input logic [63:0] b,
                        output logic [N-1:0] gnt, output logic mid_v, output logic v,
                        output logic [63:0] s, output logic c, output logic [1:0] id);
        req_valid = N'(1 << idx);
        req_a = '0;
        req_b = '0;
        req_a[64*idx +: 64] = a;
        req_b[64*idx +: 64] = b;
        rsp_ready = 1'b1;
        @(negedge clk);
        gnt = req_ready;
        cyc();
        req_valid = '0;
        req_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        mid_v = rsp_valid;
        cyc();
        @(negedge clk);
        v  = rsp_valid;
        s  = rsp_sum;
        c  = rsp_carry;
        id = rsp_id;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_a = '1;
        req_b = '1;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_sum !== 64'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", rsp_sum); end
        total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", rsp_carry); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        rst = 1'b0;
        req_valid = '0;
        cyc();
        @(negedge clk);
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        logic mv, v, c;
        logic [63:0] s;
        logic [1:0] id;
        do_reset();
        send(1, 64'd5, 64'd7, g, mv, v, s, c, id);
        total++; if (g !== 3'b010) begin bad++; $display("FAIL single_grant got=%b exp=010", g); end
        total++; if (mv !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", mv); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", v); end
        total++; if (s !== 64'd12) begin bad++; $display("FAIL single_sum got=%0d exp=12", s); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL single_carry got=%b exp=0", c); end
        total++; if (id !== 2'd1) begin bad++; $display("FAIL single_id got=%0d exp=1", id); end
    endtask

    task automatic test_overflow();
        logic [N-1:0] g;
        logic mv, v, c;
        logic [63:0] s, a, b;
        logic [1:0] id;
        logic [64:0] e;
        do_reset();
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, g, mv, v, s, c, id);
        total++; if ({c, s} !== {1'b1, 64'h0}) begin bad++; $display("FAIL ovf_ones got=%b_%h exp=1_0", c, s); end
        total++; if (id !== 2'd0) begin bad++; $display("FAIL ovf_ones_id got=%0d exp=0", id); end
        send(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, g, mv, v, s, c, id);
        total++; if ({c, s} !== {1'b1, 64'h0}) begin bad++; $display("FAIL ovf_msb got=%b_%h exp=1_0", c, s); end
        total++; if (id !== 2'd2) begin bad++; $display("FAIL ovf_msb_id got=%0d exp=2", id); end
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = {1'b0, a} + {1'b0, b};
        send(1, a, b, g, mv, v, s, c, id);
        total++; if ({c, s} !== e) begin bad++; $display("FAIL rand_add got=%h exp=%h", {c, s}, e); end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int cycs[$];
        int rids[$];
        do_reset();
        req_valid = '1;
        req_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) ids.push_back(i);
                cycs.push_back(c);
            end
            if (rsp_valid) rids.push_back(int'(rsp_id));
            cyc();
        end
        req_valid = '0;
        total++; if (ids.size() < 6) begin bad++; $display("FAIL rr_count got=%0d exp>=6", ids.size()); end
        total++; if (cycs.size() == 0 || cycs[0] != 0) begin bad++; $display("FAIL rr_first got=%0d exp=0", cycs.size() ? cycs[0] : -1); end
        for (int k = 0; k < 6 && k < ids.size(); k++) begin
            total++; if (ids[k] != k % N) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, ids[k], k % N); end
        end
        for (int k = 1; k < 6 && k < cycs.size(); k++) begin
            total++; if (cycs[k] - cycs[k-1] != 3) begin bad++; $display("FAIL rr_gap[%0d] got=%0d exp=3", k, cycs[k] - cycs[k-1]); end
        end
        for (int k = 0; k < 5 && k < rids.size(); k++) begin
            total++; if (rids[k] != k % N) begin bad++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", k, rids[k], k % N); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b;
        logic [64:0] e;
        do_reset();
        a = {$urandom, $urandom};
        b = 64'hFFFF_FFFF_0000_0000 | 64'($urandom);
        e = {1'b0, a} + {1'b0, b};
        req_valid = 3'b010;
        req_a[127:64] = a;
        req_b[127:64] = b;
        rsp_ready = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL bp_grant got=%b exp=010", req_ready); end
        cyc();
        req_valid = 3'b111;
        cyc();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, rsp_valid); end
            total++; if ({rsp_carry, rsp_sum} !== e) begin bad++; $display("FAIL bp_sum[%0d] got=%h exp=%h", k, {rsp_carry, rsp_sum}, e); end
            total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL bp_id[%0d] got=%0d exp=1", k, rsp_id); end
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=000", k, req_ready); end
            if (k < 5) cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
        total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL bp_ptr got=%b exp=100", req_ready); end
        total++; if ({rsp_carry, rsp_sum} !== e) begin bad++; $display("FAIL bp_hold_after got=%h exp=%h", {rsp_carry, rsp_sum}, e); end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_valid = 3'b001;
        req_a[63:0] = 64'd100;
        req_b[63:0] = 64'd23;
        @(negedge clk);
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_grant got=%b exp=001", req_ready); end
        cyc();
        req_valid = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped[%0d] got=%b exp=0", k, rsp_valid); end
            cyc();
        end
        req_valid = 3'b111;
        @(negedge clk);
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_ptr got=%b exp=001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        cyc();
        req_valid = 3'b100;
        cyc();
        @(negedge clk);
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL wd_resp_ready got=%b exp=000", req_ready); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wd_resp_valid got=%b exp=1", rsp_valid); end
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL wd_idle_ready[%0d] got=%b exp=000", k, req_ready); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wd_idle_valid[%0d] got=%b exp=0", k, rsp_valid); end
            cyc();
        end
        req_valid = 3'b010;
        @(negedge clk);
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL wd_next_grant got=%b exp=010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_random();
        int ptr = 0;
        int w;
        int resp_at = 0;
        bit busy = 0;
        logic [64:0] exp_res = '0;
        int exp_id = 0;
        logic [N-1:0] exp_oh;
        logic [63:0] pick[4];
        pick[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        pick[1] = 64'h8000_0000_0000_0000;
        pick[2] = 64'h0;
        pick[3] = 64'h1;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[64*i +: 64] = ($urandom % 4 == 0) ? pick[$urandom % 4] : {$urandom, $urandom};
                req_b[64*i +: 64] = ($urandom % 4 == 0) ? pick[$urandom % 4] : {$urandom, $urandom};
            end
            rsp_ready = ($urandom % 3) != 0;
            @(negedge clk);
            if (!busy) begin
                w = rr_pick(req_valid, ptr);
                exp_oh = (w < 0) ? '0 : N'(1 << w);
                total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, req_ready, exp_oh); end
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle_valid n=%0d got=%b exp=0", n, rsp_valid); end
                if (w >= 0) begin
                    exp_res = {1'b0, req_a[64*w +: 64]} + {1'b0, req_b[64*w +: 64]};
                    exp_id = w;
                    busy = 1;
                    resp_at = n + 2;
                    ptr = (w + 1) % N;
                end
            end else begin
                total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rnd_busy_ready n=%0d got=%b exp=000", n, req_ready); end
                if (n >= resp_at) begin
                    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=1", n, rsp_valid); end
                    total++; if ({rsp_carry, rsp_sum} !== exp_res) begin bad++; $display("FAIL rnd_sum n=%0d got=%h exp=%h", n, {rsp_carry, rsp_sum}, exp_res); end
                    total++; if (int'(rsp_id) != exp_id) begin bad++; $display("FAIL rnd_id n=%0d got=%0d exp=%0d", n, rsp_id, exp_id); end
                    if (rsp_ready) busy = 0;
                end else begin
                    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_early n=%0d got=%b exp=0", n, rsp_valid); end
                end
            end
            cyc();
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
